// File: rtl/viterbi_ber_monitor_if.sv
// ---------------------------------------------------------------------------
// viterbi_ber_monitor_if
//
// Bundles the control, encoder-side and decoder-side signals of the
// Viterbi BER monitor so the block and its environment share one port.
//
//   master : the monitor itself (drives encoder_o, counters and status)
//   slave  : the surrounding environment (drives start, config, decoder)
//
// Signals
//   start_i / mode_i / ext_data_i / num_bits_i / skip_i : run control
//   encoder_o / enable_encoder_o                         : bit to the encoder
//   decoder_i / dec_valid_i                              : decoded bit stream
//   good_o / bad_o                                       : compare counters
//   busy_o / done_o / full_o / unf_o                     : status
// ---------------------------------------------------------------------------
interface viterbi_ber_monitor_if #(
  parameter int CNT_W  = 32,
  parameter int SKIP_W = 8
) ();

  logic              start_i;
  logic              mode_i;
  logic              ext_data_i;
  logic [CNT_W-1:0]  num_bits_i;
  logic [SKIP_W-1:0] skip_i;

  logic              encoder_o;
  logic              enable_encoder_o;

  logic              decoder_i;
  logic              dec_valid_i;

  logic [CNT_W-1:0]  good_o;
  logic [CNT_W-1:0]  bad_o;
  logic              busy_o;
  logic              done_o;
  logic              full_o;
  logic              unf_o;

  modport master (
    input  start_i, mode_i, ext_data_i, num_bits_i, skip_i,
    input  decoder_i, dec_valid_i,
    output encoder_o, enable_encoder_o,
    output good_o, bad_o, busy_o, done_o, full_o, unf_o
  );

  modport slave (
    output start_i, mode_i, ext_data_i, num_bits_i, skip_i,
    output decoder_i, dec_valid_i,
    input  encoder_o, enable_encoder_o,
    input  good_o, bad_o, busy_o, done_o, full_o, unf_o
  );

endinterface

// File: rtl/viterbi_ber_monitor.sv
// ---------------------------------------------------------------------------
// viterbi_ber_monitor
//
// Stimulus source and scoreboard for the Viterbi transmit/receive path.
// Sends num_bits bits (internal PRBS7 or an external stream) to the
// convolutional encoder, remembers every bit sent in a circular history,
// and compares each decoded bit, in order, against that history.
//
// Parameters
//   DEPTH  : history depth in bits (power of 2, >= 4)
//   CNT_W  : width of num_bits and of the good/bad counters
//   SKIP_W : width of the skip count
//
// Ports
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : viterbi_ber_monitor_if.master
//     start_i, mode_i, ext_data_i, num_bits_i, skip_i : run control
//     encoder_o, enable_encoder_o                       : encoder side
//     decoder_i, dec_valid_i                            : decoder side
//     good_o, bad_o, busy_o, done_o, full_o, unf_o      : results/status
// ---------------------------------------------------------------------------
module viterbi_ber_monitor #(
  parameter int DEPTH  = 2048,
  parameter int CNT_W  = 32,
  parameter int SKIP_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  viterbi_ber_monitor_if.master bus
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [SKIP_W-1:0] SKIP_ONE = {{(SKIP_W-1){1'b0}}, 1'b1};
  localparam logic [AW:0]       PTR_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]       OCC_FULL = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0]       OCC_ZERO = '0;
  localparam logic [6:0]        LFSR_SEED = 7'h7F;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SKIP = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  // PRBS7, x^7 + x^6 + 1: output is l[6], feedback enters at l[0].
  function automatic logic [6:0] lfsr_next(input logic [6:0] l);
    return {l[5:0], l[6] ^ l[5]};
  endfunction

  state_t             state_q, state_d;
  logic               mode_q;
  logic [CNT_W-1:0]   num_bits_q;
  logic [CNT_W-1:0]   tx_sent_q;
  logic [CNT_W-1:0]   rx_cnt_q;
  logic [CNT_W-1:0]   good_q;
  logic [CNT_W-1:0]   bad_q;
  logic [SKIP_W-1:0]  skip_cnt_q;
  logic [6:0]         lfsr_q;
  logic [AW:0]        wr_cnt_q;
  logic [AW:0]        rd_cnt_q;
  logic               unf_q;
  logic               hist [DEPTH];

  logic [AW:0]        occ;
  logic               full;
  logic               empty;
  logic               busy;
  logic               enc_bit;
  logic               hist_bit;
  logic               start_ok;
  logic               tx_en;
  logic               rd_en;
  logic               skip_dec;
  logic               unf_set;

  // Extra MSB on the pointers distinguishes full (diff = DEPTH) from empty.
  assign occ      = wr_cnt_q - rd_cnt_q;
  assign full     = (occ == OCC_FULL);
  assign empty    = (occ == OCC_ZERO);
  assign busy     = (state_q == SKIP) || (state_q == RUN);
  assign enc_bit  = mode_q ? bus.ext_data_i : lfsr_q[6];
  assign hist_bit = hist[rd_cnt_q[AW-1:0]];

  always_comb begin
    state_d  = state_q;
    start_ok = 1'b0;
    rd_en    = 1'b0;
    skip_dec = 1'b0;
    unf_set  = 1'b0;
    tx_en    = busy && (tx_sent_q < num_bits_q) && !full;

    case (state_q)
      IDLE, DONE: begin
        if (bus.start_i) begin
          start_ok = 1'b1;
          if (bus.num_bits_i == '0) begin
            state_d = DONE;
          end else if (bus.skip_i != '0) begin
            state_d = SKIP;
          end else begin
            state_d = RUN;
          end
        end
      end
      SKIP: begin
        if (bus.dec_valid_i) begin
          skip_dec = 1'b1;
          if (skip_cnt_q == SKIP_ONE) begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (bus.dec_valid_i) begin
          if (empty) begin
            unf_set = 1'b1;
          end else begin
            rd_en = 1'b1;
            // Leave RUN on the same edge that records the final compare.
            if (rx_cnt_q == num_bits_q - CNT_ONE) begin
              state_d = DONE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q     <= 1'b0;
      num_bits_q <= '0;
      skip_cnt_q <= '0;
      lfsr_q     <= LFSR_SEED;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      tx_sent_q  <= '0;
      rx_cnt_q   <= '0;
      good_q     <= '0;
      bad_q      <= '0;
      unf_q      <= 1'b0;
    end else if (start_ok) begin
      mode_q     <= bus.mode_i;
      num_bits_q <= bus.num_bits_i;
      skip_cnt_q <= bus.skip_i;
      lfsr_q     <= LFSR_SEED;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      tx_sent_q  <= '0;
      rx_cnt_q   <= '0;
      good_q     <= '0;
      bad_q      <= '0;
      unf_q      <= 1'b0;
    end else begin
      // Transmit side
      if (tx_en) begin
        wr_cnt_q  <= wr_cnt_q + PTR_ONE;
        tx_sent_q <= tx_sent_q + CNT_ONE;
        if (!mode_q) begin
          lfsr_q <= lfsr_next(lfsr_q);
        end
      end
      // Receive side
      if (skip_dec) begin
        skip_cnt_q <= skip_cnt_q - SKIP_ONE;
      end
      if (rd_en) begin
        rd_cnt_q <= rd_cnt_q + PTR_ONE;
        rx_cnt_q <= rx_cnt_q + CNT_ONE;
        if (bus.decoder_i == hist_bit) begin
          good_q <= sat_inc(good_q);
        end else begin
          bad_q <= sat_inc(bad_q);
        end
      end
      if (unf_set) begin
        unf_q <= 1'b1;
      end
    end
  end

  // History storage carries no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (tx_en) begin
      hist[wr_cnt_q[AW-1:0]] <= enc_bit;
    end
  end

  assign bus.encoder_o        = enc_bit;
  assign bus.enable_encoder_o = tx_en;
  assign bus.good_o           = good_q;
  assign bus.bad_o            = bad_q;
  assign bus.busy_o           = busy;
  assign bus.done_o           = (state_q == DONE);
  assign bus.full_o           = full;
  assign bus.unf_o            = unf_q;

endmodule

// File: tb/tb_viterbi_ber_monitor.sv
// ---------------------------------------------------------------------------
// tb_viterbi_ber_monitor
//
// Drives two monitors in lock-step (DEPTH 2048 and DEPTH 16) from the same
// control inputs. Each has its own loopback delay line feeding its encoder
// output back as the decoded stream, with optional bit inversion and manual
// valid pulses for skip/underflow cases.
// ---------------------------------------------------------------------------
module tb_viterbi_ber_monitor;

  localparam int CNT_W   = 32;
  localparam int SKIP_W  = 8;
  localparam int DEPTH_B = 2048;
  localparam int DEPTH_S = 16;

  typedef struct {
    bit mode;
    int nbits;
    int skip;
    int delay;
    int flip;
    int exp_good;
    int exp_bad;
    bit exp_full;
  } vec_t;

  logic clk;
  logic rst_n;
  logic start, mode, ext_data, man_vld, man_bit, loop_en;
  logic [CNT_W-1:0]  num_bits;
  logic [SKIP_W-1:0] skip;
  int delay;
  int flip_idx;

  int checks;
  int failures;

  viterbi_ber_monitor_if #(.CNT_W(CNT_W), .SKIP_W(SKIP_W)) b_if ();
  viterbi_ber_monitor_if #(.CNT_W(CNT_W), .SKIP_W(SKIP_W)) s_if ();

  viterbi_ber_monitor #(.DEPTH(DEPTH_B), .CNT_W(CNT_W), .SKIP_W(SKIP_W)) dut_big (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b_if)
  );

  viterbi_ber_monitor #(.DEPTH(DEPTH_S), .CNT_W(CNT_W), .SKIP_W(SKIP_W)) dut_small (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (s_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Index 0 = big instance, 1 = small instance
  logic             enc [2];
  logic             en [2];
  logic             full_s [2];
  logic             busy_s [2];
  logic             done_s [2];
  logic             unf_s [2];
  logic [CNT_W-1:0] good_s [2];
  logic [CNT_W-1:0] bad_s [2];
  logic             loop_vld [2];
  logic             dec_v [2];
  logic             dec_b [2];
  logic [63:0]      bit_dl [2];
  logic [63:0]      vld_dl [2];
  int               rx_idx [2];
  int               occ [2];
  int               mon_err;
  bit               seen_full [2];
  logic [7:0]       cap;
  int               cap_n;

  assign b_if.start_i = start;    assign s_if.start_i = start;
  assign b_if.mode_i = mode;      assign s_if.mode_i = mode;
  assign b_if.ext_data_i = ext_data; assign s_if.ext_data_i = ext_data;
  assign b_if.num_bits_i = num_bits; assign s_if.num_bits_i = num_bits;
  assign b_if.skip_i = skip;      assign s_if.skip_i = skip;
  assign b_if.decoder_i = dec_b[0];   assign s_if.decoder_i = dec_b[1];
  assign b_if.dec_valid_i = dec_v[0]; assign s_if.dec_valid_i = dec_v[1];

  assign enc[0] = b_if.encoder_o;        assign enc[1] = s_if.encoder_o;
  assign en[0] = b_if.enable_encoder_o;  assign en[1] = s_if.enable_encoder_o;
  assign full_s[0] = b_if.full_o;        assign full_s[1] = s_if.full_o;
  assign busy_s[0] = b_if.busy_o;        assign busy_s[1] = s_if.busy_o;
  assign done_s[0] = b_if.done_o;        assign done_s[1] = s_if.done_o;
  assign unf_s[0] = b_if.unf_o;          assign unf_s[1] = s_if.unf_o;
  assign good_s[0] = b_if.good_o;        assign good_s[1] = s_if.good_o;
  assign bad_s[0] = b_if.bad_o;          assign bad_s[1] = s_if.bad_o;

  for (genvar g = 0; g < 2; g++) begin : g_loop
    assign loop_vld[g] = loop_en && vld_dl[g][delay-1];
    assign dec_v[g]    = man_vld | loop_vld[g];
    assign dec_b[g]    = man_vld ? man_bit : (bit_dl[g][delay-1] ^ (rx_idx[g] == flip_idx));
  end

  always @(negedge clk) ext_data <= 1'($urandom);

  // Loopback delay lines and reference occupancy (writes minus looped reads)
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        bit_dl[i] <= '0; vld_dl[i] <= '0; rx_idx[i] <= 0; occ[i] <= 0;
      end
    end else if (start) begin
      for (int i = 0; i < 2; i++) begin
        bit_dl[i] <= '0; vld_dl[i] <= '0; rx_idx[i] <= 0; occ[i] <= 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        bit_dl[i] <= {bit_dl[i][62:0], enc[i]};
        vld_dl[i] <= {vld_dl[i][62:0], en[i]};
        if (loop_vld[i]) rx_idx[i] <= rx_idx[i] + 1;
        occ[i] <= occ[i] + (en[i] ? 1 : 0) - (loop_vld[i] ? 1 : 0);
      end
    end
  end

  // full_o must track the reference occupancy and block the encoder enable
  always @(posedge clk) begin
    int e;
    e = 0;
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        if (full_s[i] !== (occ[i] == ((i == 0) ? DEPTH_B : DEPTH_S))) e++;
        if (full_s[i] && en[i]) e++;
      end
      mon_err <= mon_err + e;
    end
    if (start) begin
      seen_full[0] <= 1'b0;
      seen_full[1] <= 1'b0;
      cap   <= '0;
      cap_n <= 0;
    end else begin
      if (full_s[0]) seen_full[0] <= 1'b1;
      if (full_s[1]) seen_full[1] <= 1'b1;
      if (en[0] && cap_n < 8) begin
        cap   <= {cap[6:0], enc[0]};
        cap_n <= cap_n + 1;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    for (int i = 0; i < 2; i++) begin
      string n;
      n = $sformatf("%s[%0d]", tag, i);
      check({n, " good"}, good_s[i], 0);
      check({n, " bad"}, bad_s[i], 0);
      check({n, " busy"}, busy_s[i], 0);
      check({n, " done"}, done_s[i], 0);
      check({n, " full"}, full_s[i], 0);
      check({n, " unf"}, unf_s[i], 0);
      check({n, " enable"}, en[i], 0);
      check({n, " encoder"}, enc[i], 1);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int cyc;
    mode = v.mode; num_bits = CNT_W'(v.nbits); skip = SKIP_W'(v.skip);
    delay = v.delay; flip_idx = v.flip; loop_en = 1'b1;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s[%0d] busy_after_start", tag, i), busy_s[i], v.nbits != 0);
      check($sformatf("%s[%0d] enable_after_start", tag, i), en[i], v.nbits != 0);
    end
    if (v.skip != 0) begin
      man_vld = 1'b1;
      for (int k = 0; k < v.skip; k++) begin
        man_bit = 1'($urandom);
        @(negedge clk);
      end
      man_vld = 1'b0;
      for (int i = 0; i < 2; i++)
        check($sformatf("%s[%0d] no_cmp_in_skip", tag, i), good_s[i] + bad_s[i], 0);
      repeat (v.delay + 1 - v.skip) @(negedge clk);
      for (int i = 0; i < 2; i++)
        check($sformatf("%s[%0d] first_cmp", tag, i), good_s[i], 1);
    end
    cyc = 0;
    while (!(done_s[0] && done_s[1]) && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s[%0d] done", tag, i), done_s[i], 1);
      check($sformatf("%s[%0d] busy", tag, i), busy_s[i], 0);
      check($sformatf("%s[%0d] good", tag, i), good_s[i], v.exp_good);
      check($sformatf("%s[%0d] bad", tag, i), bad_s[i], v.exp_bad);
      check($sformatf("%s[%0d] unf", tag, i), unf_s[i], 0);
    end
    check({tag, " big_never_full"}, seen_full[0], 0);
    check({tag, " small_full_seen"}, seen_full[1], v.exp_full);
    check({tag, " full_tracking"}, mon_err, 0);
  endtask

  initial begin
    vec_t vecs[8];
    int sent;
    //          mode nbits skip dly flip  good bad full
    vecs[0] = '{1'b0,   8,   0,  5,  -1,    8,  0, 1'b0};
    vecs[1] = '{1'b0, 256,   0,  5,  -1,  256,  0, 1'b0};
    vecs[2] = '{1'b0, 256,   0,  5, 100,  255,  1, 1'b0};
    vecs[3] = '{1'b0, 256,   3,  5,  -1,  256,  0, 1'b0};
    vecs[4] = '{1'b0, 256,   0, 40,  -1,  256,  0, 1'b1};
    vecs[5] = '{1'b0,   0,   0,  5,  -1,    0,  0, 1'b0};
    vecs[6] = '{1'b1,  64,   0,  7,  -1,   64,  0, 1'b0};
    vecs[7] = '{1'b0, 130,   0,  3,   0,  129,  1, 1'b0};

    checks = 0; failures = 0; mon_err = 0;
    start = 1'b0; mode = 1'b0; num_bits = '0; skip = '0;
    delay = 5; flip_idx = -1; man_vld = 1'b0; man_bit = 1'b0; loop_en = 1'b0;
    rst_n = 1'b0;

    #12;
    check_reset("reset");
    @(negedge clk) rst_n = 1'b1;

    run_vec(vecs[0], "prbs8");
    check("prbs_first8", cap, 8'hFE);
    for (int i = 1; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Underflow: decoded valid on the first RUN edge, before any write lands
    loop_en = 1'b0; mode = 1'b0; num_bits = 256; skip = '0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0; man_vld = 1'b1; man_bit = 1'b0;
    @(negedge clk) man_vld = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("unf[%0d] flag", i), unf_s[i], 1);
      check($sformatf("unf[%0d] good", i), good_s[i], 0);
      check($sformatf("unf[%0d] bad", i), bad_s[i], 0);
    end
    #2 rst_n = 1'b0;
    #1 check_reset("reset_after_unf");
    @(negedge clk) rst_n = 1'b1;

    // Asynchronous reset in the middle of a run, around the 50th bit
    loop_en = 1'b1; delay = 5; flip_idx = -1; num_bits = 256;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    sent = 0;
    for (int c = 0; c < 1000 && sent < 50; c++) begin
      if (en[0]) sent++;
      @(negedge clk);
    end
    check("midrun_reached_50", sent, 50);
    #2 rst_n = 1'b0;
    #1 check_reset("midrun_reset");
    @(negedge clk);
    check_reset("midrun_reset_held");
    rst_n = 1'b1;
    run_vec(vecs[1], "fresh");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/viterbi_ber_monitor.md
# viterbi_ber_monitor

Synthesizable, parametrised stimulus-and-scoreboard block for the Viterbi transmit/receive path. It sources a bit stream (internal PRBS7 or external) into the convolutional encoder, keeps a circular history of every bit sent, and compares each decoded bit against that history in order. It accumulates good and bad counts in hardware, with skip-count alignment, history backpressure and underflow detection.

## Interface
- DEPTH, 2048: history buffer depth in bits; power of 2, at least 4.
- CNT_W, 32: width of the bit-count input and the good/bad counters.
- SKIP_W, 8: width of the skip-count input.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- start_i  in  1  one-cycle pulse; ignored unless the state is IDLE or DONE.
- mode_i  in  1  0 = internal PRBS7 source, 1 = external source from ext_data_i; sampled on start.
- ext_data_i  in  1  external source bit, used when mode = 1.
- num_bits_i  in  CNT_W  number of bits to transmit and compare; sampled on start; 0 means finish at once.
- skip_i  in  SKIP_W  number of leading decoder_i valid bits to discard; sampled on start.
- encoder_o  out  1  bit driven to the encoder.
- enable_encoder_o  out  1  encoder_o is valid and is consumed this cycle.
- decoder_i  in  1  decoded bit.
- dec_valid_i  in  1  decoder_i is valid this cycle.
- good_o  out  CNT_W  count of matching comparisons.
- bad_o  out  CNT_W  count of mismatching comparisons.
- busy_o  out  1  state is SKIP or RUN.
- done_o  out  1  state is DONE.
- full_o  out  1  history occupancy equals DEPTH.
- unf_o  out  1  sticky flag: a valid decoded bit arrived while the history was empty.

## Operation
- FSM states: IDLE, SKIP, RUN, DONE.
- Transitions on start:
  - IDLE/DONE -> SKIP on start when skip_i ≠ 0.
  - IDLE/DONE -> RUN on start when skip_i = 0.
  - IDLE/DONE -> DONE on start when num_bits_i = 0.
- SKIP -> RUN after skip_i valid decoded bits have been discarded.
- RUN -> DONE when the compare count reaches num_bits.
- DONE holds until the next start or reset.
- Start clears: good, bad, unf, write/read pointers, the tx counter, the rx counter, and the skip counter. It also reseeds the LFSR to 7'h7F.
- Transmit side, active in SKIP and RUN:
  - enable_encoder_o = (tx_sent < num_bits) AND NOT full.
  - On each enabled cycle the bit is written to hist[wr_ptr]; wr_ptr and tx_sent increment.
  - In PRBS mode the LFSR advances on each enabled cycle.
- PRBS7 generator:
  - Polynomial x^7+x^6+1, register l[6:0].
  - encoder_o = l[6]; next state = {l[5:0], l[6]^l[5]}.
  - Period 127.
- External mode: encoder_o = ext_data_i, passed combinationally.
- Receive side:
  - In SKIP, each dec_valid_i decrements the skip count; no compare takes place and the history is untouched.
  - In RUN, each dec_valid_i with occupancy > 0 compares decoder_i against hist[rd_ptr]. On a match good increments, otherwise bad increments. rd_ptr and the rx counter then increment.
  - A dec_valid_i in RUN with occupancy = 0 sets unf_o. Nothing is counted and the pointers do not move.
  - dec_valid_i in IDLE or DONE is ignored.
- Occupancy = wr_count − rd_count. Pointers wrap modulo DEPTH and use log2(DEPTH)+1-bit counters to tell full from empty.
- A read and a write in the same cycle are both performed. A read only sees bits written on earlier edges; there is no same-cycle bypass.
- good_o and bad_o saturate at 2^CNT_W−1.

## Timing
- Reset value of every output is 0, except encoder_o, which is 1 in PRBS mode because of the seed. State resets to IDLE and the LFSR to 7'h7F.
- Reset is asynchronous, takes effect mid-operation, aborts any run, and discards the history.
- enable_encoder_o rises in the first cycle after the start edge, provided the history is not full.
- Compare latency is 1 cycle: good_o/bad_o reflect a compare on the edge that samples dec_valid_i.
- done_o rises in the same update as the last count, so it is visible the cycle after the last compare is sampled.
- busy_o falls in that same cycle.
- full_o and enable_encoder_o are updated together; while full, a simultaneous read frees a slot from the next cycle only.
- A start pulse during SKIP or RUN has no effect.

## Test plan
- Reset: with rst low, all outputs are 0 except encoder_o = 1. After release in PRBS mode, start with num_bits = 8 → the first 8 encoder_o bits are 1,1,1,1,1,1,1,0.
- Loopback, PRBS mode, DEPTH = 2048, num_bits = 256, skip = 0, decoder_i/dec_valid_i = encoder_o/enable_encoder_o delayed 5 cycles → good = 256, bad = 0, done = 1, unf = 0.
- Same setup with decoded bit index 100 inverted → good = 255, bad = 1.
- Skip: skip = 3, three garbage valid pulses, then the delayed loopback → good = 256, bad = 0; the first compare happens on the 4th valid.
- Backpressure: DEPTH = 16, loopback delay 40 cycles, num_bits = 256 → full_o asserts and enable_encoder_o drops at occupancy 16; final good = 256, bad = 0.
- Corner cases:
  - dec_valid_i pulse in RUN before any write → unf = 1, counts stay 0.
  - rst low at the 50th bit → outputs return to reset values immediately.
  - A fresh start then completes 256/0.
